pixel_stream_reader: RTL
========================

Name: pixel_stream_reader

Overview:
- Read-side controller for the 8-bit-write / 32-bit-read pixel memory.
- Issues 32-bit word reads on the memory's read port (EN_B/ADDR_B/DOUT_B) and unpacks each word into four 8-bit pixels, lowest byte first.
- Presents the pixels on a valid/ready stream to the downstream processing pipeline, with a start/busy/done command interface.

Parameters:
- DATA_WIDTH_A, 8, pixel width (memory write-port width)
- DATA_WIDTH_B, 32, memory read-port word width; PIX_PER_WORD = DATA_WIDTH_B/DATA_WIDTH_A = 4
- DEPTH, 16384, memory size in bits; WORDS = DEPTH/DATA_WIDTH_B = 512; AW = $clog2(WORDS) = 9
- CW, 12, pixel-count width (max transfer = WORDS*PIX_PER_WORD = 2048 pixels)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command pulse; sampled only in IDLE
- start_word  in  AW  first word address of the transfer
- pix_count  in  CW  number of pixels to stream (0..2048)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after final pixel handshake (or immediately for count 0)
- mem_en_b  out  1  read enable to memory EN_B
- mem_addr_b  out  AW  read address to memory ADDR_B
- mem_dout_b  in  DATA_WIDTH_B  memory DOUT_B; valid on the cycle after mem_en_b (registered read)
- pix_valid  out  1  output pixel valid
- pix_ready  in  1  downstream ready
- pix_data  out  DATA_WIDTH_A  output pixel
- pix_last  out  1  marks final pixel of transfer, qualified by pix_valid

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, mem_en_b, pix_valid, pix_last = 0; mem_addr_b, pix_data = 0; internal counters and word registers cleared. Reset mid-transfer aborts with no done pulse.
- States: IDLE, REQ, CAPT, STREAM, FIN.
- IDLE: start=1 latches start_word and pix_count, sets busy. pix_count=0 goes to FIN; otherwise REQ.
- REQ: mem_en_b=1, mem_addr_b = current word address; go to CAPT.
- CAPT: mem_dout_b latched into word_reg; byte index = 0; go to STREAM.
- STREAM: pix_valid=1, pix_data = word_reg[8*idx +: 8].
  - Handshake occurs when pix_valid and pix_ready are both high; it advances idx and decrements the remaining count.
  - pix_data and pix_last hold stable while pix_valid && !pix_ready.
- End of word: after the handshake at idx=3, or on reaching remaining=0 mid-word, the word address increments. The next state is REQ if pixels remain, else FIN.
- Partial last word: only the remaining low-order bytes are emitted; the upper bytes are discarded.
- pix_last = pix_valid && remaining==1.
- FIN: done=1 for one cycle, busy=0 on the next edge, return to IDLE.
- Word address wraps modulo WORDS (511 -> 0).
- start asserted while busy is ignored; inputs are not re-sampled.
- Latency: first pix_valid is 3 cycles after the start edge.
- Without prefetch: 6 cycles per full word at pix_ready=1 (REQ, CAPT, 4x STREAM).
- mem_en_b is never asserted outside REQ (and the prefetch slot when enabled).

Optional Feature:
- Macro: READ_PREFETCH_EN.
- Defined:
  - Adds a next_word register plus a valid flag.
  - In the first STREAM cycle of each word, if at least one further word is needed, mem_en_b pulses with the next address. The data is captured into next_word on the following cycle.
  - At end of word, word_reg loads next_word and STREAM continues directly, skipping REQ/CAPT.
  - Sustained rate: 1 pixel/cycle with pix_ready held high.
  - The prefetch is issued only once per word; it is held unaffected by downstream stalls.
  - Prefetch never reads beyond the last needed word.
- Undefined: the behaviour is exactly the non-prefetch FSM above.

Test Plan:
- Memory word0=0x44332211, word1=0x88776655; start_word=0, pix_count=8, pix_ready=1 -> pixels 11,22,33,44,55,66,77,88; pix_last on 88; done 1 cycle later. Throughput is 12 stream+fetch cycles without prefetch and 8 consecutive valid cycles with READ_PREFETCH_EN.
- Partial word: start_word=5, word5=0xDDCCBBAA, pix_count=3 -> AA,BB,CC; pix_last on CC; exactly one mem_en_b, with addr 5.
- Backpressure: pix_ready toggled 1,0,0,1 while streaming word 0xA3A2A1A0 -> pix_data holds A1 through the stalls; no pixel is dropped or duplicated.
- Wrap: start_word=511, pix_count=8 -> reads addr 511 then addr 0; pixel order is correct.
- pix_count=0 -> no mem_en_b, done pulses 2 cycles after start. Start while busy -> ignored, and transfer 1 completes unchanged.
- Async reset during STREAM (rst_n=0 for 1 cycle mid-edge) -> all outputs 0 immediately, no done pulse. A new start afterwards runs normally.

Source files
------------

// File: rtl/pixel_stream_reader.sv
// Read-side controller for the 8-bit-write / 32-bit-read pixel memory: fetches words and streams bytes LSB first.
// Optional READ_PREFETCH_EN overlaps the next word fetch with streaming for 1 pixel/cycle throughput.
module pixel_stream_reader #(
    parameter int unsigned DATA_WIDTH_A = 8,
    parameter int unsigned DATA_WIDTH_B = 32,
    parameter int unsigned DEPTH        = 16384,
    parameter int unsigned CW           = 12,
    localparam int unsigned WORDS       = DEPTH / DATA_WIDTH_B,
    localparam int unsigned AW          = $clog2(WORDS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [AW-1:0]           start_word,
    input  logic [CW-1:0]           pix_count,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_en_b,
    output logic [AW-1:0]           mem_addr_b,
    input  logic [DATA_WIDTH_B-1:0] mem_dout_b,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [DATA_WIDTH_A-1:0] pix_data,
    output logic                    pix_last
);

    localparam int unsigned PIX_PER_WORD = DATA_WIDTH_B / DATA_WIDTH_A;
    localparam int unsigned IW           = $clog2(PIX_PER_WORD);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        CAPT   = 3'd2,
        STREAM = 3'd3,
        FIN    = 3'd4
    } state_t;

    state_t                  state, state_n;
    logic [AW-1:0]           addr, addr_n;
    logic [CW-1:0]           remaining, remaining_n;
    logic [IW-1:0]           idx, idx_n;
    logic [DATA_WIDTH_B-1:0] word_reg, word_reg_n;

    logic                    busy_n, done_n, mem_en_b_n;
    logic [AW-1:0]           mem_addr_b_n;
    logic                    pix_valid_n, pix_last_n;
    logic [DATA_WIDTH_A-1:0] pix_data_n;

    logic                    hs_c;
    logic [CW-1:0]           rem_dec_c;
    logic [IW-1:0]           idx_inc_c;
    logic [AW-1:0]           addr_inc_c;
    logic                    go_req_c;

`ifdef READ_PREFETCH_EN
    localparam logic [CW-1:0] PPW_C = CW'(PIX_PER_WORD);

    logic [DATA_WIDTH_B-1:0] next_word, next_word_n;
    logic                    next_valid, next_valid_n;
    logic                    pf_cap, pf_cap_n;
`endif

    assign hs_c       = pix_valid && pix_ready;
    assign rem_dec_c  = remaining - CW'(1);
    assign idx_inc_c  = idx + IW'(1);
    assign addr_inc_c = addr + AW'(1);

    // Next-state and next-output logic; every register holds unless a state moves it
    always_comb begin
        state_n      = state;
        addr_n       = addr;
        remaining_n  = remaining;
        idx_n        = idx;
        word_reg_n   = word_reg;
        busy_n       = busy;
        done_n       = 1'b0;
        mem_en_b_n   = 1'b0;
        mem_addr_b_n = mem_addr_b;
        pix_valid_n  = pix_valid;
        pix_data_n   = pix_data;
        pix_last_n   = pix_last;
        go_req_c     = 1'b0;
`ifdef READ_PREFETCH_EN
        next_word_n  = next_word;
        next_valid_n = next_valid;
        // A read enable seen while streaming is always a prefetch; its data lands one cycle later
        pf_cap_n     = mem_en_b && (state == STREAM);
        if (pf_cap) begin
            next_word_n  = mem_dout_b;
            next_valid_n = 1'b1;
        end
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    busy_n      = 1'b1;
                    addr_n      = start_word;
                    remaining_n = pix_count;
                    idx_n       = '0;
`ifdef READ_PREFETCH_EN
                    next_valid_n = 1'b0;
`endif
                    if (pix_count == '0) begin
                        state_n = FIN;
                    end else begin
                        state_n      = REQ;
                        mem_en_b_n   = 1'b0;
                        mem_en_b_n   = 1'b1;
                        mem_addr_b_n = start_word;
                    end
                end
            end

            REQ: begin
                state_n = CAPT;
            end

            CAPT: begin
                word_reg_n  = mem_dout_b;
                idx_n       = '0;
                pix_valid_n = 1'b1;
                pix_data_n  = mem_dout_b[DATA_WIDTH_A-1:0];
                pix_last_n  = (remaining == CW'(1));
                state_n     = STREAM;
`ifdef READ_PREFETCH_EN
                if (remaining > PPW_C) begin
                    mem_en_b_n   = 1'b1;
                    mem_addr_b_n = addr_inc_c;
                end
`endif
            end

            STREAM: begin
                if (hs_c) begin
                    remaining_n = rem_dec_c;
                    idx_n       = idx_inc_c;
                    if (rem_dec_c == '0) begin
                        // Transfer ends, possibly mid-word; unused upper bytes are dropped
                        addr_n      = addr_inc_c;
                        pix_valid_n = 1'b0;
                        pix_last_n  = 1'b0;
                        state_n     = FIN;
                    end else if (idx == IW'(PIX_PER_WORD - 1)) begin
                        addr_n = addr_inc_c;
`ifdef READ_PREFETCH_EN
                        if (next_valid) begin
                            word_reg_n   = next_word;
                            next_valid_n = 1'b0;
                            idx_n        = '0;
                            pix_data_n   = next_word[DATA_WIDTH_A-1:0];
                            pix_last_n   = (rem_dec_c == CW'(1));
                            if (rem_dec_c > PPW_C) begin
                                mem_en_b_n   = 1'b1;
                                mem_addr_b_n = addr_inc_c + AW'(1);
                            end
                        end else begin
                            go_req_c = 1'b1;
                        end
`else
                        go_req_c = 1'b1;
`endif
                    end else begin
                        pix_data_n = DATA_WIDTH_A'(word_reg >> (DATA_WIDTH_A * idx_inc_c));
                        pix_last_n = (rem_dec_c == CW'(1));
                    end

                    if (go_req_c) begin
                        pix_valid_n  = 1'b0;
                        pix_last_n   = 1'b0;
                        mem_en_b_n   = 1'b1;
                        mem_addr_b_n = addr_inc_c;
                        state_n      = REQ;
                    end
                end
            end

            FIN: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            idx        <= '0;
            word_reg   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_en_b   <= 1'b0;
            mem_addr_b <= '0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            pix_last   <= 1'b0;
`ifdef READ_PREFETCH_EN
            next_word  <= '0;
            next_valid <= 1'b0;
            pf_cap     <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            remaining  <= remaining_n;
            idx        <= idx_n;
            word_reg   <= word_reg_n;
            busy       <= busy_n;
            done       <= done_n;
            mem_en_b   <= mem_en_b_n;
            mem_addr_b <= mem_addr_b_n;
            pix_valid  <= pix_valid_n;
            pix_data   <= pix_data_n;
            pix_last   <= pix_last_n;
`ifdef READ_PREFETCH_EN
            next_word  <= next_word_n;
            next_valid <= next_valid_n;
            pf_cap     <= pf_cap_n;
`endif
        end
    end

endmodule
